// File: rtl/gan_param_loader_pkg.sv
// Shared constants, slot map and FSM encoding for the GAN parameter loader.
// Slot indices follow the order in which the host streams parameters.
package gan_param_loader_pkg;

  localparam int WIDTH         = 8;
  localparam int WIDTH_L8      = 77;
  localparam int NUM_PARAMS    = 77;
  localparam int SETTLE_CYCLES = 20;

  localparam int IDX_W = $clog2(NUM_PARAMS + 1);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam int IDX_X1    = 0;
  localparam int IDX_W1_11 = 4;
  localparam int IDX_B1_1  = 20;
  localparam int IDX_W2_11 = 24;
  localparam int IDX_B2_1  = 32;
  localparam int IDX_W3_11 = 34;
  localparam int IDX_B3_1  = 36;
  localparam int IDX_W4_11 = 37;
  localparam int IDX_B4_1  = 38;
  localparam int IDX_W5_11 = 39;
  localparam int IDX_B5_1  = 40;
  localparam int IDX_W6_11 = 41;
  localparam int IDX_B6_1  = 43;
  localparam int IDX_W7_11 = 45;
  localparam int IDX_B7_1  = 53;
  localparam int IDX_W8_11 = 57;
  localparam int IDX_B8_1  = 73;
  localparam int IDX_B8_4  = 76;

  typedef logic signed [WIDTH-1:0] param_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/gan_param_loader_if.sv
// Byte-stream valid/ready channel carrying GAN parameters.
// The host drives data; the loader answers with ready.
interface gan_param_loader_if;
  import gan_param_loader_pkg::*;

  logic         s_valid;
  logic         s_ready;
  logic [WIDTH-1:0] s_data;
  logic         s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/gan_param_loader.sv
// Loads a 77-beat parameter frame into a flat bus for the GAN,
// waits for the datapath to settle, then captures its outputs.
module gan_param_loader
  import gan_param_loader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  gan_param_loader_if.slave s,
  output logic [NUM_PARAMS*WIDTH-1:0] params_flat,
  output logic params_valid,
  input  logic signed [WIDTH_L8-1:0] gan_out1,
  input  logic signed [WIDTH_L8-1:0] gan_out2,
  input  logic signed [WIDTH_L8-1:0] gan_out3,
  input  logic signed [WIDTH_L8-1:0] gan_out4,
  output logic signed [WIDTH_L8-1:0] res1,
  output logic signed [WIDTH_L8-1:0] res2,
  output logic signed [WIDTH_L8-1:0] res3,
  output logic signed [WIDTH_L8-1:0] res4,
  output logic res_valid,
  output logic busy,
  output logic err
);

  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic pv_n, rv_n, err_n;
  logic wr_en, cap;
  logic ready_q;
  logic accept, at_last;
  param_t slot [NUM_PARAMS];

  assign accept  = s.s_valid & ready_q;
  assign at_last = (idx == IDX_W'(NUM_PARAMS - 1));

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    pv_n    = params_valid;
    rv_n    = res_valid;
    err_n   = err;
    wr_en   = 1'b0;
    cap     = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n = ST_LOAD;
          idx_n   = '0;
          pv_n    = 1'b0;
          rv_n    = 1'b0;
          err_n   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          idx_n = idx + IDX_W'(1);
          if (s.s_last && at_last) begin
            state_n = ST_SETTLE;
            cnt_n   = '0;
            pv_n    = 1'b1;
          end else if (s.s_last || at_last) begin
            // Framing error: keep partial slots, drop back to idle.
            state_n = ST_IDLE;
            err_n   = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          cap     = 1'b1;
          rv_n    = 1'b1;
          state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      cnt          <= '0;
      ready_q      <= 1'b0;
      params_valid <= 1'b0;
      res_valid    <= 1'b0;
      err          <= 1'b0;
      res1         <= '0;
      res2         <= '0;
      res3         <= '0;
      res4         <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      ready_q      <= (state_n == ST_LOAD);
      params_valid <= pv_n;
      res_valid    <= rv_n;
      err          <= err_n;
      if (cap) begin
        res1 <= gan_out1;
        res2 <= gan_out2;
        res3 <= gan_out3;
        res4 <= gan_out4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_PARAMS; k++) begin
        slot[k] <= '0;
      end
    end else if (wr_en) begin
      slot[idx] <= s.s_data;
    end
  end

  for (genvar k = 0; k < NUM_PARAMS; k++) begin : g_flat
    assign params_flat[k*WIDTH +: WIDTH] = slot[k];
  end

  assign s.s_ready = ready_q;
  assign busy = (state == ST_LOAD) || (state == ST_SETTLE);

endmodule

// File: tb/tb_gan_param_loader.sv
// Directed bench for gan_param_loader: framing, settle latency,
// error recovery, async reset and frame reload.
module tb_gan_param_loader;
  import gan_param_loader_pkg::*;

  localparam int FW = NUM_PARAMS * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [FW-1:0] params_flat;
  logic params_valid, res_valid, busy, err;
  logic [WIDTH_L8-1:0] g1, g2, g3, g4;
  logic [WIDTH_L8-1:0] res1, res2, res3, res4;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_cyc = 0;

  gan_param_loader_if s ();

  gan_param_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s            (s),
    .params_flat  (params_flat),
    .params_valid (params_valid),
    .gan_out1     (g1),
    .gan_out2     (g2),
    .gan_out3     (g3),
    .gan_out4     (g4),
    .res1         (res1),
    .res2         (res2),
    .res3         (res3),
    .res4         (res4),
    .res_valid    (res_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] vval(input int k, input bit alt);
    logic [7:0] v;
    v = 8'((k * 37 + 11) & 255);
    case (k)
      0: v = 8'h00;
      1: v = 8'h01;
      2: v = 8'h01;
      3: v = 8'h00;
      4: v = 8'h06;
      76: v = alt ? 8'h0A : 8'hF6;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [FW-1:0] vflat(input bit alt);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NUM_PARAMS; k++) f[k*WIDTH +: WIDTH] = vval(k, alt);
    return f;
  endfunction

  function automatic logic [7:0] slot(input int k);
    return params_flat[k*WIDTH +: WIDTH];
  endfunction

  task automatic check(input string tag, input logic [639:0] obs,
                       input logic [639:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    s.s_valid = 1'b1;
    s.s_data  = d;
    s.s_last  = l;
    while (!s.s_ready && t < 50) begin
      tick();
      t++;
    end
    check("push_ready", s.s_ready, 1);
    tick();
    last_cyc  = cyc;
    s.s_valid = 1'b0;
    s.s_last  = 1'b0;
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    while (!res_valid && t < 60) begin
      tick();
      t++;
    end
    check("res_valid", res_valid, 1);
    check("latency", cyc - last_cyc, SETTLE_CYCLES);
  endtask

  int idxs[18] = '{IDX_X1, IDX_W1_11, IDX_B1_1, IDX_W2_11, IDX_B2_1,
                   IDX_W3_11, IDX_B3_1, IDX_W4_11, IDX_B4_1, IDX_W5_11,
                   IDX_B5_1, IDX_W6_11, IDX_B6_1, IDX_W7_11, IDX_B7_1,
                   IDX_W8_11, IDX_B8_1, IDX_B8_4};

  initial begin
    s.s_valid = 1'b0;
    s.s_data  = '0;
    s.s_last  = 1'b0;
    g1 = 77'h1_0123_4567_89AB_CDEF_012;
    g2 = 77'h0_F00D_CAFE_1234_5678_9AB;
    g3 = 77'h1_FFFF_FFFF_FFFF_FFFF_FFF;
    g4 = 77'h0_0000_0000_0000_0000_07B;

    // Reset state
    repeat (2) tick();
    check("rst_flat", params_flat, 0);
    check("rst_ready", s.s_ready, 0);
    check("rst_pv", params_valid, 0);
    check("rst_rv", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_res1", res1, 0);
    rst = 1'b1;
    tick();

    // Clean frame, back to back
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_ready", s.s_ready, 1);
    for (int k = 0; k < NUM_PARAMS - 1; k++) push(vval(k, 0), 1'b0);
    check("t1_pv_before", params_valid, 0);
    push(vval(NUM_PARAMS - 1, 0), 1'b1);
    check("t1_pv", params_valid, 1);
    check("t1_busy_settle", busy, 1);
    check("t1_ready_off", s.s_ready, 0);
    check("t1_slot0", slot(0), 8'h00);
    check("t1_slot4", slot(4), 8'h06);
    check("t1_slot76", slot(76), 8'hF6);
    check("t1_flat", params_flat, vflat(0));
    foreach (idxs[i]) check("t1_idx", slot(idxs[i]), vval(idxs[i], 0));
    wait_res();
    check("t1_res1", res1, g1);
    check("t1_res2", res2, g2);
    check("t1_res3", res3, g3);
    check("t1_res4", res4, g4);
    check("t1_busy_done", busy, 0);
    g1 = 77'h0_1111_2222_3333_4444_555;
    tick();
    check("t1_res1_hold", res1, 77'h1_0123_4567_89AB_CDEF_012);
    check("t1_pv_hold", params_valid, 1);

    // Start in DONE drops both valids; then early s_last
    pulse_start();
    check("t6_pv_drop", params_valid, 0);
    check("t6_rv_drop", res_valid, 0);
    for (int k = 0; k < 10; k++) push(vval(k, 0), 1'b0);
    push(vval(10, 0), 1'b1);
    check("t3_err", err, 1);
    check("t3_busy", busy, 0);
    check("t3_pv", params_valid, 0);
    check("t3_ready", s.s_ready, 0);
    repeat (3) tick();
    check("t3_err_sticky", err, 1);
    pulse_start();
    check("t3_err_clr", err, 0);
    check("t3_ready_on", s.s_ready, 1);

    // Gapped frame with stray start pulses
    for (int k = 0; k < NUM_PARAMS; k++) begin
      if ($urandom_range(0, 1) == 1) tick();
      if (k == 30) begin
        pulse_start();
        check("t4_busy", busy, 1);
        check("t4_ready", s.s_ready, 1);
      end
      push(vval(k, 0), k == NUM_PARAMS - 1);
    end
    pulse_start();
    check("t4_busy_settle", busy, 1);
    wait_res();
    check("t4_flat", params_flat, vflat(0));
    check("t4_pv", params_valid, 1);
    check("t4_err", err, 0);
    check("t4_res1", res1, 77'h0_1111_2222_3333_4444_555);

    // Async reset mid-load
    pulse_start();
    for (int k = 0; k < 40; k++) push(vval(k, 1), 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t5_flat", params_flat, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", s.s_ready, 0);
    check("t5_pv", params_valid, 0);
    check("t5_rv", res_valid, 0);
    check("t5_res1", res1, 0);
    tick();
    rst = 1'b1;
    tick();
    g1 = 77'h0_0000_0000_0000_0000_001;
    g3 = 77'h1_8000_0000_0000_0000_000;
    pulse_start();
    for (int k = 0; k < NUM_PARAMS; k++) push(vval(k, 1), k == NUM_PARAMS - 1);
    check("t5_slot0", slot(0), 8'h00);
    check("t5_slot76", slot(76), 8'h0A);
    check("t5_flat2", params_flat, vflat(1));
    check("t5_pv2", params_valid, 1);
    wait_res();
    check("t5_res1b", res1, 77'h0_0000_0000_0000_0000_001);
    check("t5_res3b", res3, 77'h1_8000_0000_0000_0000_000);
    check("t5_res4b", res4, 77'h0_0000_0000_0000_0000_07B);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
